// File: rtl/float_pkg.sv
// rtl/float_pkg.sv - shared constants and state type for the float_to_int converter
package float_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_CONVERT,
    S_SIGN,
    S_PUT
  } state_t;
endpackage

// File: rtl/float_unpack.sv
// rtl/float_unpack.sv - combinational binary32 field split and classification
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0]       data,
  output logic              sign,
  output logic [9:0]        exp_unb,
  output logic [FRAC_W-1:0] frac,
  output logic              is_zero,
  output logic              is_denorm,
  output logic              is_inf,
  output logic              is_nan
);
  logic [EXP_W-1:0] exp_raw;

  assign sign    = data[31];
  assign exp_raw = data[30:23];
  assign frac    = data[22:0];
  // Two's-complement unbiased exponent, range -127..128
  assign exp_unb = 10'({2'b00, exp_raw}) - 10'(EXP_BIAS);

  assign is_zero   = (exp_raw == '0) && (frac == '0);
  assign is_denorm = (exp_raw == '0) && (frac != '0);
  assign is_inf    = (&exp_raw) && (frac == '0);
  assign is_nan    = (&exp_raw) && (frac != '0);
endmodule

// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - iterative binary32 to int32 converter; FLOAT_TO_INT_ROUND_EN selects round-to-nearest-even
module float_to_int
  import float_pkg::*;
#(
  parameter int          SHIFT_STEP = 1,
  parameter logic [31:0] NAN_VALUE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_ovf,
  output logic        out_inexact
);
  if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_bad_step
    $error("float_to_int: SHIFT_STEP must be 1, 2, 4 or 8");
  end

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] m_q, m_d;
  logic [5:0]  rem_q, rem_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic [31:0] out_data_q, out_data_d;
  logic        ovf_q, ovf_d;
  logic        inexact_q, inexact_d;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic        guard_q, guard_d;
`endif

  logic              u_sign, u_zero, u_denorm, u_inf, u_nan;
  logic [9:0]        u_exp;
  logic [FRAC_W-1:0] u_frac;

  float_unpack u_unpack (
    .data      (op_q),
    .sign      (u_sign),
    .exp_unb   (u_exp),
    .frac      (u_frac),
    .is_zero   (u_zero),
    .is_denorm (u_denorm),
    .is_inf    (u_inf),
    .is_nan    (u_nan)
  );

  logic signed [9:0] e_s;
  logic [5:0]        amt;
  logic [31:0]       lost_mask;
  logic [31:0]       mag;
  logic [31:0]       sat_value;

  assign e_s       = $signed(u_exp);
  assign amt       = (rem_q < 6'(SHIFT_STEP)) ? rem_q : 6'(SHIFT_STEP);
  assign lost_mask = (32'h1 << amt) - 32'h1;
  assign sat_value = u_sign ? INT_MIN : INT_MAX;
`ifdef FLOAT_TO_INT_ROUND_EN
  assign mag = m_q + {31'd0, guard_q & (sticky_q | m_q[0])};
`else
  assign mag = m_q;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    m_d        = m_q;
    rem_d      = rem_q;
    sticky_d   = sticky_q;
    sign_d     = sign_q;
    special_d  = special_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    inexact_d  = inexact_q;
`ifdef FLOAT_TO_INT_ROUND_EN
    guard_d    = guard_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_data;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        // Special results also pass through SIGN so every path spends two cycles before PUT
        m_d        = {1'b1, u_frac, 8'b0};
        sign_d     = u_sign;
        sticky_d   = 1'b0;
        special_d  = 1'b1;
        out_data_d = '0;
        ovf_d      = 1'b0;
        inexact_d  = 1'b0;
        state_d    = S_SIGN;
`ifdef FLOAT_TO_INT_ROUND_EN
        guard_d    = 1'b0;
`endif
        if (u_zero || u_denorm) begin
          inexact_d = u_denorm;
        end else if (u_nan) begin
          out_data_d = NAN_VALUE;
          ovf_d      = 1'b1;
        end else if (u_inf) begin
          out_data_d = sat_value;
          ovf_d      = 1'b1;
        end else if (e_s >= 10'sd31) begin
          out_data_d = sat_value;
          ovf_d      = !(u_sign && e_s == 10'sd31 && u_frac == '0);
`ifdef FLOAT_TO_INT_ROUND_EN
        end else if (e_s < -10'sd1) begin
`else
        end else if (e_s < 10'sd0) begin
`endif
          inexact_d = 1'b1;
        end else begin
          rem_d     = 6'(10'sd31 - e_s);
          special_d = 1'b0;
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        m_d   = m_q >> amt;
        rem_d = rem_q - amt;
`ifdef FLOAT_TO_INT_ROUND_EN
        // Top discarded bit becomes guard; the previous guard folds into sticky
        guard_d  = |(m_q & (32'h1 << (amt - 6'd1)));
        sticky_d = sticky_q | guard_q | (|(m_q & (lost_mask >> 1)));
`else
        sticky_d = sticky_q | (|(m_q & lost_mask));
`endif
        if (rem_d == 6'd0) state_d = S_SIGN;
      end
      S_SIGN: begin
        if (!special_q) begin
          out_data_d = sign_q ? (32'd0 - mag) : mag;
          ovf_d      = 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
          inexact_d  = guard_q | sticky_q;
          if (!sign_q && mag[31]) begin
            out_data_d = INT_MAX;
            ovf_d      = 1'b1;
          end
`else
          inexact_d  = sticky_q;
`endif
        end
        state_d = S_PUT;
      end
      S_PUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      m_q        <= '0;
      rem_q      <= '0;
      sticky_q   <= 1'b0;
      sign_q     <= 1'b0;
      special_q  <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      inexact_q  <= 1'b0;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      m_q        <= m_d;
      rem_q      <= rem_d;
      sticky_q   <= sticky_d;
      sign_q     <= sign_d;
      special_q  <= special_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      inexact_q  <= inexact_d;
`ifdef FLOAT_TO_INT_ROUND_EN
      guard_q    <= guard_d;
`endif
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_PUT);
  assign out_data    = out_data_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inexact_q;
endmodule

// File: tb/tb_float_to_int.sv
// tb/tb_float_to_int.sv - self-checking bench for float_to_int (vectors, corner sequences, random vs reference)
module tb_float_to_int;
  localparam int          SHIFT_STEP = 1;
  localparam logic [31:0] NAN_VALUE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_ovf;
  logic        out_inexact;

  int n_checks = 0;
  int n_fail   = 0;

  float_to_int #(.SHIFT_STEP(SHIFT_STEP), .NAN_VALUE(NAN_VALUE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value = 1.f * 2^e evaluated on a 64-bit integer, split into quotient and remainder
  function automatic void ref_conv(input logic [31:0] x, output logic [31:0] d,
                                   output logic o, output logic i);
    int     exp_b = int'(x[30:23]);
    int     e     = exp_b - 127;
    longint mant  = longint'({1'b1, x[22:0]});
    longint q, r, half;
    int     sh;
    d = '0; o = 1'b0; i = 1'b0;
    if (exp_b == 0) begin
      i = (x[22:0] != 0);
    end else if (exp_b == 255) begin
      o = 1'b1;
      d = (x[22:0] != 0) ? NAN_VALUE : (x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end else if (e >= 31) begin
      if (x[31] && e == 31 && x[22:0] == 0) d = 32'h8000_0000;
      else begin
        o = 1'b1;
        d = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else begin
      sh = 23 - e;
      if (sh > 60) sh = 60;
      if (sh <= 0) begin
        q = mant << (-sh); r = 0; half = 0;
      end else begin
        q = mant >> sh; r = mant - (q << sh); half = longint'(1) << (sh - 1);
      end
      i = (r != 0);
`ifdef FLOAT_TO_INT_ROUND_EN
      if (r > half || (r == half && r != 0 && q[0])) q = q + 1;
`endif
      if (!x[31] && q >= 64'sd2147483648) begin
        d = 32'h7FFF_FFFF; o = 1'b1;
      end else begin
        d = x[31] ? 32'(-q) : 32'(q);
      end
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] x);
    int exp_b = int'(x[30:23]);
    int e     = exp_b - 127;
    int lo;
`ifdef FLOAT_TO_INT_ROUND_EN
    lo = -1;
`else
    lo = 0;
`endif
    if (exp_b == 0 || exp_b == 255 || e >= 31 || e < lo) return 2;
    return 2 + (31 - e + SHIFT_STEP - 1) / SHIFT_STEP;
  endfunction

  task automatic start_op(input logic [31:0] x);
    int wait_cnt = 0;
    @(negedge clk);
    while (!in_ready && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    in_data  = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] x, output logic [31:0] d, output logic o,
                        output logic i, output int lat);
    start_op(x);
    wait_valid(lat);
    d = out_data; o = out_ovf; i = out_inexact;
    take_out();
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] data;
    logic        ovf;
    logic        inx;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d, x, ed;
    logic        o, i, eo, ei;
    int          lat;

    vecs.push_back('{32'h4049_0FDB, 32'd3,          1'b0, 1'b1});
    vecs.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 1'b1});
`ifdef FLOAT_TO_INT_ROUND_EN
    vecs.push_back('{32'h3FC0_0000, 32'd2,          1'b0, 1'b1});
    vecs.push_back('{32'h3F40_0000, 32'd1,          1'b0, 1'b1});
`else
    vecs.push_back('{32'h3FC0_0000, 32'd1,          1'b0, 1'b1});
    vecs.push_back('{32'h3F40_0000, 32'd0,          1'b0, 1'b1});
`endif
    vecs.push_back('{32'h3F00_0000, 32'd0,          1'b0, 1'b1});
    vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'h7FC0_0000, NAN_VALUE,      1'b1, 1'b0});
    vecs.push_back('{32'h0000_0001, 32'd0,          1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'd0,          1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'd1,          1'b0, 1'b0});
    vecs.push_back('{32'hC0E0_0000, 32'hFFFF_FFF9, 1'b0, 1'b0});
    vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0});
    vecs.push_back('{32'hCF00_0001, 32'h8000_0000, 1'b1, 1'b0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_out_inexact", out_inexact, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    foreach (vecs[k]) begin
      run_op(vecs[k].din, d, o, i, lat);
      check($sformatf("vec%0d_data", k), d, vecs[k].data);
      check($sformatf("vec%0d_ovf", k), o, vecs[k].ovf);
      check($sformatf("vec%0d_inexact", k), i, vecs[k].inx);
      check($sformatf("vec%0d_latency", k), lat, exp_latency(vecs[k].din));
    end

    // Backpressure: outputs held, no input acceptance
    start_op(32'h4040_0000);
    wait_valid(lat);
    check("bp_latency", lat, exp_latency(32'h4040_0000));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", out_valid, 1);
      check("bp_data_held", out_data, 32'd3);
      check("bp_ovf_held", out_ovf, 0);
      check("bp_inexact_held", out_inexact, 0);
      check("bp_in_ready_low", in_ready, 0);
    end
    take_out();
    check("bp_valid_drop", out_valid, 0);
    run_op(32'h3F80_0000, d, o, i, lat);
    check("b2b_first", d, 32'd1);
    run_op(32'hC0E0_0000, d, o, i, lat);
    check("b2b_second", d, 32'hFFFF_FFF9);

    // Reset in the middle of CONVERT
    start_op(32'h3F80_0000);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("midrst_no_stale", out_valid, 0);
    run_op(32'hC0E0_0000, d, o, i, lat);
    check("midrst_next_data", d, 32'hFFFF_FFF9);
    check("midrst_next_inexact", i, 0);

    // Randomized against the reference model
    for (int n = 0; n < 250; n++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(110, 160));
      ref_conv(x, ed, eo, ei);
      run_op(x, d, o, i, lat);
      check($sformatf("rnd%0d_data(in %h)", n, x), d, ed);
      check($sformatf("rnd%0d_ovf(in %h)", n, x), o, eo);
      check($sformatf("rnd%0d_inexact(in %h)", n, x), i, ei);
      check($sformatf("rnd%0d_latency(in %h)", n, x), lat, exp_latency(x));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
